// File: rtl/counter_modn_updown.sv
// counter_modn_updown: modulo-N up/down counter with synchronous clear and load,
// wrap or saturate at the boundaries, terminal-count strobe for cascading, and
// an out-of-range load flag. Count arithmetic stays WIDTH bits wide, so
// MODULUS == 2**WIDTH needs no extra carry bit.
module counter_modn_updown #(
   parameter int WIDTH       = 3,
   parameter int MODULUS     = 6,
   parameter int STOP_AT_END = 0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count_out,
   output logic             tc_out,
   output logic             zero,
   output logic             load_err
);

   // Top of the count range, expressed in the counter's own width.
   localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] C_ZERO = WIDTH'(0);
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_load_err;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_load_err_nxt;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_load_oor;

   // One enabled step in the requested direction. The boundary test comes
   // first, so the +1/-1 never has to wrap on its own; this keeps the count
   // in range even when MODULUS fills the whole WIDTH-bit space.
   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cnt,
                                                input logic             dir_up);
      logic [WIDTH-1:0] v_nxt;
      v_nxt = cnt;
      if (dir_up) begin
         if (cnt >= C_MAX) begin
            v_nxt = (STOP_AT_END != 0) ? C_MAX : C_ZERO;
         end else begin
            v_nxt = cnt + C_ONE;
         end
      end else begin
         if (cnt == C_ZERO) begin
            v_nxt = (STOP_AT_END != 0) ? C_ZERO : C_MAX;
         end else begin
            v_nxt = cnt - C_ONE;
         end
      end
      return v_nxt;
   endfunction

   assign w_at_max   = (r_count == C_MAX);
   assign w_at_zero  = (r_count == C_ZERO);
   // A load_value above C_MAX cannot occur when MODULUS == 2**WIDTH.
   assign w_load_oor = (load_value > C_MAX);

   // Next-state selection: clear beats load, and load beats counting.
   always_comb begin
      w_count_nxt    = r_count;
      w_load_err_nxt = 1'b0;
      if (clear) begin
         w_count_nxt = C_ZERO;
      end else if (load) begin
         if (w_load_oor) begin
            w_count_nxt    = C_MAX;
            w_load_err_nxt = 1'b1;
         end else begin
            w_count_nxt = load_value;
         end
      end else if (en) begin
         w_count_nxt = f_step(r_count, up);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Count and error-flag registers. Reset clears them at once, without
   // waiting for a clock edge, and drops any operation that was under way.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= C_ZERO;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   assign count_out = r_count;
   assign load_err  = r_load_err;
   assign zero      = w_at_zero;
   // The strobe fires only on an edge that will actually count across a
   // boundary, so a cascaded stage steps exactly once per roll-over.
   assign tc_out    = en & ~clear & ~load & ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_counter_modn_updown.sv
// Scoreboard bench for counter_modn_updown: a wrapping instance, a saturating
// instance and a two-stage decimal cascade. Stimulus pushes hand-computed
// expectations; the monitor pops them on the falling clock edge (or on a
// mid-cycle sample event) and compares them against the outputs.
module tb_counter_modn_updown;

   typedef struct {
      int         dut;
      int         step;
      logic [3:0] cnt;
      logic       tc;
      logic       zr;
      logic       err;
      logic [3:0] cnt2;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       a_en, a_up, a_clear, a_load;
   logic [2:0] a_lv, a_cnt;
   logic       a_tc, a_zero, a_err;
   logic       b_en, b_up, b_clear, b_load;
   logic [2:0] b_lv, b_cnt;
   logic       b_tc, b_zero, b_err;
   logic       c_en;
   logic [3:0] c1_cnt, c2_cnt;
   logic       c1_tc, c1_zero, c1_err, c2_tc, c2_zero, c2_err;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;
   event mon_ev;

   counter_modn_updown #(.WIDTH(3), .MODULUS(6), .STOP_AT_END(0)) u_wrap (
      .clk(clk), .reset(reset), .en(a_en), .up(a_up), .clear(a_clear),
      .load(a_load), .load_value(a_lv), .count_out(a_cnt), .tc_out(a_tc),
      .zero(a_zero), .load_err(a_err));

   counter_modn_updown #(.WIDTH(3), .MODULUS(6), .STOP_AT_END(1)) u_sat (
      .clk(clk), .reset(reset), .en(b_en), .up(b_up), .clear(b_clear),
      .load(b_load), .load_value(b_lv), .count_out(b_cnt), .tc_out(b_tc),
      .zero(b_zero), .load_err(b_err));

   counter_modn_updown #(.WIDTH(4), .MODULUS(10), .STOP_AT_END(0)) u_stage1 (
      .clk(clk), .reset(reset), .en(c_en), .up(1'b1), .clear(1'b0),
      .load(1'b0), .load_value(4'd0), .count_out(c1_cnt), .tc_out(c1_tc),
      .zero(c1_zero), .load_err(c1_err));

   counter_modn_updown #(.WIDTH(4), .MODULUS(10), .STOP_AT_END(0)) u_stage2 (
      .clk(clk), .reset(reset), .en(c1_tc), .up(1'b1), .clear(1'b0),
      .load(1'b0), .load_value(4'd0), .count_out(c2_cnt), .tc_out(c2_tc),
      .zero(c2_zero), .load_err(c2_err));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string nm, input int stp, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0d required=%0d", nm, stp, act, req);
      end
   endfunction

   task automatic push(input int dut, input logic [3:0] cnt, input logic tc,
                       input logic zr, input logic err, input logic [3:0] cnt2);
      exp_t e;
      e.dut = dut; e.step = step_no; e.cnt = cnt; e.tc = tc;
      e.zr = zr; e.err = err; e.cnt2 = cnt2;
      step_no++;
      sb_q.push_back(e);
   endtask

   // Drive one cycle on the wrapping instance and record what must follow the edge.
   task automatic step_a(input logic en, input logic up, input logic clr, input logic ld,
                         input logic [2:0] lv, input logic [2:0] ec, input logic et,
                         input logic ez, input logic ee);
      @(negedge clk); #1;
      a_en = en; a_up = up; a_clear = clr; a_load = ld; a_lv = lv;
      push(0, {1'b0, ec}, et, ez, ee, 4'd0);
   endtask

   task automatic step_b(input logic en, input logic up, input logic clr, input logic ld,
                         input logic [2:0] lv, input logic [2:0] ec, input logic et,
                         input logic ez, input logic ee);
      @(negedge clk); #1;
      b_en = en; b_up = up; b_clear = clr; b_load = ld; b_lv = lv;
      push(1, {1'b0, ec}, et, ez, ee, 4'd0);
   endtask

   // 3 ns reset pulse between edges: outputs must clear before the next edge,
   // and the first edge after release counts up from 0.
   task automatic async_rst();
      @(negedge clk); #1;
      a_en = 1'b0; a_load = 1'b0; a_clear = 1'b0;
      reset = 1'b0;
      #1;
      push(0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      -> mon_ev;
      #2;
      reset = 1'b1;
      a_en = 1'b1; a_up = 1'b1;
      push(0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   // Monitor: compares one queued expectation per falling edge or sample event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or mon_ev);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.dut)
               0: begin
                  chk("a_count", e.step, int'(a_cnt), int'(e.cnt));
                  chk("a_tc", e.step, int'(a_tc), int'(e.tc));
                  chk("a_zero", e.step, int'(a_zero), int'(e.zr));
                  chk("a_load_err", e.step, int'(a_err), int'(e.err));
               end
               1: begin
                  chk("b_count", e.step, int'(b_cnt), int'(e.cnt));
                  chk("b_tc", e.step, int'(b_tc), int'(e.tc));
                  chk("b_zero", e.step, int'(b_zero), int'(e.zr));
                  chk("b_load_err", e.step, int'(b_err), int'(e.err));
               end
               default: begin
                  chk("c1_count", e.step, int'(c1_cnt), int'(e.cnt));
                  chk("c1_tc", e.step, int'(c1_tc), int'(e.tc));
                  chk("c1_zero", e.step, int'(c1_zero), int'(e.zr));
                  chk("c2_count", e.step, int'(c2_cnt), int'(e.cnt2));
                  chk("c2_zero", e.step, int'(c2_zero), int'(e.cnt2 == 4'd0));
                  chk("c2_tc", e.step, int'(c2_tc), int'(e.tc && e.cnt2 == 4'd9));
                  chk("c_load_err", e.step, int'(c1_err | c2_err), 0);
               end
            endcase
         end
      end
   end

   // Directed stimulus.
   initial begin
      int up_tab[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
      int dn_tab[4]  = '{1, 0, 5, 4};
      int sat_tab[5] = '{4, 5, 5, 5, 5};

      reset = 1'b0;
      a_en = 1'b1; a_up = 1'b0; a_clear = 1'b0; a_load = 1'b0; a_lv = 3'd0;
      b_en = 1'b0; b_up = 1'b0; b_clear = 1'b0; b_load = 1'b0; b_lv = 3'd0;
      c_en = 1'b0;
      // During reset the count reads 0: zero=1, and a down-enable shows tc=1.
      #2;
      push(0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
      -> mon_ev;
      #9;
      a_en = 1'b0;
      reset = 1'b1;

      // Up-count wrap: 1,2,3,4,5,0,1,2 with tc only at 5.
      for (int i = 0; i < 8; i++) begin
         step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'(up_tab[i]), up_tab[i] == 5, up_tab[i] == 0, 1'b0);
      end
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
      // Down-count wrap from a load of 2: 1,0,5,4 with tc only at 0.
      step_a(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step_a(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'(dn_tab[i]), dn_tab[i] == 0, dn_tab[i] == 0, 1'b0);
      end
      // Direction changes with no dead cycle.
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0);
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0);
      // Priority: clear over load over enable; load masks tc.
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
      step_a(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
      step_a(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0);
      // Out-of-range loads saturate to 5 with a one-cycle error pulse.
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd5, 1'b0, 1'b0, 1'b1);
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0);
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 3'd5, 1'b0, 1'b0, 1'b1);
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      // Reset while the error flag is high, then reset at count 4.
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd5, 1'b0, 1'b0, 1'b1);
      async_rst();
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0);
      async_rst();
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);

      // Saturating instance: up from 3 then down from 1.
      step_b(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'(sat_tab[i]), sat_tab[i] == 5, 1'b0, 1'b0);
      end
      step_b(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
      step_b(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
      step_b(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
      step_b(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);

      // Decimal cascade: after k edges stage one holds k%10 and stage two k/10.
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk); #1;
         c_en = 1'b1;
         push(2, 4'(k % 10), (k % 10) == 9, (k % 10) == 0, 1'b0, 4'(k / 10));
      end
      @(negedge clk); #1;
      c_en = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("sb_drain", step_no, sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_modn_updown.md
COUNTER_MODN_UPDOWN -- requirements
Module: counter_modn_updown

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of the count.
REQ-002 SHALL have parameter MODULUS, default 6: count range 0..MODULUS-1, with 2 <= MODULUS <= 2^WIDTH.
REQ-003 SHALL have parameter STOP_AT_END, default 0: 0 = wrap at the boundary, 1 = saturate at the boundary.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear to 0.
REQ-009 SHALL have port load, input, 1 bit: synchronous load of load_value.
REQ-010 SHALL have port load_value, input, WIDTH bits: value to load.
REQ-011 SHALL have port count_out, output, WIDTH bits: current count (registered).
REQ-012 SHALL have port tc_out, output, 1 bit: terminal-count strobe for cascading (combinational).
REQ-013 SHALL have port zero, output, 1 bit: count_out == 0 (combinational).
REQ-014 SHALL have port load_err, output, 1 bit: out-of-range load flag (registered, one-cycle pulse).

Function
REQ-015 SHALL apply per-edge priority clear > load > en; with none asserted, count_out holds.
REQ-016 SHALL, on clear=1, set count_out=0 on the next edge, regardless of load/en/up.
REQ-017 SHALL, on load=1 (clear=0) with load_value < MODULUS, set count_out=load_value on the next edge.
REQ-018 SHALL, on load=1 (clear=0) with load_value >= MODULUS, set count_out=MODULUS-1 on the next edge and set load_err=1 for exactly that following cycle.
REQ-019 SHALL drive load_err=0 in every cycle not covered by REQ-018.
REQ-020 SHALL, with en=1 and up=1, set count_out to count+1 when count < MODULUS-1.
REQ-021 SHALL, with en=1 and up=1 at count==MODULUS-1, go to 0 when STOP_AT_END=0 and hold MODULUS-1 when STOP_AT_END=1.
REQ-022 SHALL, with en=1 and up=0, set count_out to count-1 when count > 0.
REQ-023 SHALL, with en=1 and up=0 at count==0, go to MODULUS-1 when STOP_AT_END=0 and hold 0 when STOP_AT_END=1.
REQ-024 SHALL drive tc_out = en & ~clear & ~load & ((up & count==MODULUS-1) | (~up & count==0)), in both modes, so that a cascaded next stage enables on it.
REQ-025 SHALL have zero-cycle latency from inputs to tc_out and zero; count_out SHALL change one edge after the request.
REQ-026 SHALL use only arithmetic WIDTH bits wide; count_out SHALL never leave 0..MODULUS-1, including when MODULUS == 2^WIDTH.
REQ-027 SHALL allow a change of up between cycles with no dead cycle; the direction applies to the next edge.

Reset
REQ-028 SHALL, while reset=0, force count_out=0 and load_err=0 immediately, independent of clk.
REQ-029 SHALL, on reset assertion mid-count or mid-load, abort the operation; the first edge after release SHALL act on the inputs only.
REQ-030 SHALL give tc_out and zero their values for count 0 while reset is held (zero=1).

Verification (WIDTH=3, MODULUS=6 unless stated)
REQ-031 SHALL cover up-count wrap: reset, en=1, up=1 for 8 edges -> count_out 1,2,3,4,5,0,1,2; tc_out=1 only while count=5.
REQ-032 SHALL cover down-count wrap: load 2, then en=1, up=0 for 4 edges -> 1,0,5,4; tc_out=1 only while count=0.
REQ-033 SHALL cover saturation: STOP_AT_END=1, up=1 from 3 for 5 edges -> 4,5,5,5,5; down from 1 -> 0,0 with zero=1.
REQ-034 SHALL cover priority and errors: clear=1, load=1 (value 4), en=1 at count 3 -> 0; load=1 value 7 -> count 5, load_err=1 for one cycle, then 0.
REQ-035 SHALL cover async reset: reset low for 3 ns between edges at count 4 -> count_out=0 before the next edge; after release with en=1, up=1 -> 1.
REQ-036 SHALL cover a cascade: two instances (MODULUS=10, WIDTH=4), with stage two's en = stage one's tc_out, from 0 up for 25 edges -> stage two = 2, stage one = 5.
